// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous SRAM among NUM_REQ requesters.
// Optional macro SRAM_ARB_WR_PRIO_EN: valid writers outrank readers; round-robin within the class.
module sram_port_arbiter #(
  parameter  int NUM_REQ    = 2,
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 4,
  localparam int IDX_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ-1:0]             req_we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata_i,
  output logic [NUM_REQ-1:0]             req_grant_o,
  output logic [NUM_REQ-1:0]             rsp_valid_o,
  output logic [DATA_WIDTH-1:0]          rsp_data_o,
  output logic [ADDR_WIDTH-1:0]          sram_addr_o,
  output logic                           sram_we_o,
  output logic [DATA_WIDTH-1:0]          sram_wdata_o,
  input  logic [DATA_WIDTH-1:0]          sram_rdata_i
);

  localparam logic [IDX_WIDTH:0] NUM_REQ_W = (IDX_WIDTH+1)'(NUM_REQ);

  logic [IDX_WIDTH-1:0]  rr_ptr_reg, rr_ptr_next;
  logic                  rsp_pend_reg, rsp_pend_next;
  logic [IDX_WIDTH-1:0]  rsp_idx_reg, rsp_idx_next;

  logic [NUM_REQ-1:0]    eligible;
  logic                  win_found;
  logic [IDX_WIDTH-1:0]  win_idx;
  logic                  win_we;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  // Modular add that stays correct when NUM_REQ is not a power of two.
  function automatic logic [IDX_WIDTH-1:0] wrap_add(input logic [IDX_WIDTH-1:0] base,
                                                    input logic [IDX_WIDTH-1:0] step);
    logic [IDX_WIDTH:0] sum;
    sum = {1'b0, base} + {1'b0, step};
    if (sum >= NUM_REQ_W) sum = sum - NUM_REQ_W;
    return sum[IDX_WIDTH-1:0];
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[gi] = req_wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

`ifdef SRAM_ARB_WR_PRIO_EN
  logic [NUM_REQ-1:0] wr_valid;
  always_comb begin
    wr_valid = req_valid_i & req_we_i;
    eligible = (|wr_valid) ? wr_valid : req_valid_i;
    if (rst) eligible = '0;
  end
`else
  always_comb begin
    eligible = req_valid_i;
    if (rst) eligible = '0;
  end
`endif

  // First eligible requester at or after rr_ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!win_found && eligible[wrap_add(rr_ptr_reg, IDX_WIDTH'(off))]) begin
        win_found = 1'b1;
        win_idx   = wrap_add(rr_ptr_reg, IDX_WIDTH'(off));
      end
    end
  end

  assign win_we = win_found & req_we_i[win_idx];

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
      assign req_grant_o[gi] = win_found && (win_idx == IDX_WIDTH'(gi));
      assign rsp_valid_o[gi] = rsp_pend_reg && (rsp_idx_reg == IDX_WIDTH'(gi));
    end
  endgenerate

  assign sram_addr_o  = win_found ? addr_arr[win_idx] : '0;
  assign sram_we_o    = win_we;
  assign sram_wdata_o = win_we ? wdata_arr[win_idx] : '0;
  assign rsp_data_o   = sram_rdata_i;

  always_comb begin
    rr_ptr_next   = rr_ptr_reg;
    rsp_pend_next = 1'b0;
    rsp_idx_next  = rsp_idx_reg;
    if (win_found) begin
      rr_ptr_next   = wrap_add(win_idx, IDX_WIDTH'(1));
      rsp_pend_next = ~win_we;
      rsp_idx_next  = win_idx;
    end
  end

  // Async reset drops any in-flight read so no response escapes afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg   <= '0;
      rsp_pend_reg <= 1'b0;
      rsp_idx_reg  <= '0;
    end else begin
      rr_ptr_reg   <= rr_ptr_next;
      rsp_pend_reg <= rsp_pend_next;
      rsp_idx_reg  <= rsp_idx_next;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench: a two-port instance with an SRAM model and read scoreboard,
// plus a three-port instance for non-power-of-two wrap-around.
module tb_sram_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Two-requester instance
  logic [1:0]  v2 = '0, we2 = '0, g2, rv2;
  logic [7:0]  a2 = '0;
  logic [63:0] d2 = '0;
  logic [31:0] rd2, swd2;
  logic [31:0] sram_rdata2 = '0;
  logic [3:0]  sa2;
  logic        swe2;

  // Three-requester instance
  logic [2:0]  v3 = '0, we3 = '0, g3, rv3;
  logic [11:0] a3 = '0;
  logic [95:0] d3 = '0;
  logic [31:0] rd3, swd3;
  logic [31:0] sram_rdata3 = '0;
  logic [3:0]  sa3;
  logic        swe3;

  sram_port_arbiter #(.NUM_REQ(2), .DATA_WIDTH(32), .ADDR_WIDTH(4)) dut2 (
    .clk(clk), .rst(rst), .req_valid_i(v2), .req_we_i(we2), .req_addr_i(a2),
    .req_wdata_i(d2), .req_grant_o(g2), .rsp_valid_o(rv2), .rsp_data_o(rd2),
    .sram_addr_o(sa2), .sram_we_o(swe2), .sram_wdata_o(swd2), .sram_rdata_i(sram_rdata2));

  sram_port_arbiter #(.NUM_REQ(3), .DATA_WIDTH(32), .ADDR_WIDTH(4)) dut3 (
    .clk(clk), .rst(rst), .req_valid_i(v3), .req_we_i(we3), .req_addr_i(a3),
    .req_wdata_i(d3), .req_grant_o(g3), .rsp_valid_o(rv3), .rsp_data_o(rd3),
    .sram_addr_o(sa3), .sram_we_o(swe3), .sram_wdata_o(swd3), .sram_rdata_i(sram_rdata3));

  // Write-first synchronous SRAM behind dut2
  logic [31:0] mem2 [16] = '{default: '0};
  always @(posedge clk) begin
    if (swe2) mem2[sa2] <= swd2;
    sram_rdata2 <= swe2 ? swd2 : mem2[sa2];
  end

  logic [31:0] ref_mem [16] = '{default: '0};

  typedef struct {
    logic [1:0]  oh;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  // Scoreboard: every entry is due on the cycle after it was pushed.
  always @(negedge clk) begin
    exp_t e;
    vectors++;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (rv2 !== e.oh || rd2 !== e.data) begin
        errors++;
        $display("FAIL rsp: rsp_valid=%b data=%h, required rsp_valid=%b data=%h", rv2, rd2, e.oh, e.data);
      end else
        $display("rsp ok: rsp_valid=%b data=%h", rv2, rd2);
    end else if (rv2 !== 2'b00) begin
      errors++;
      $display("FAIL rsp_idle: rsp_valid=%b, required 00", rv2);
    end
  end

  task automatic set2(input logic [1:0] v, input logic [1:0] we, input logic [3:0] ad0,
                      input logic [3:0] ad1, input logic [31:0] wd0, input logic [31:0] wd1);
    v2 = v; we2 = we; a2 = {ad1, ad0}; d2 = {wd1, wd0};
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic reset_pulse();
    set2(2'b00, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    set2(2'b11, 2'b11, 4'd6, 4'd7, 32'h1111_2222, 32'h3333_4444);
    @(negedge clk);
    vectors++;
    if (g2 !== 2'b00 || swe2 !== 1'b0 || sa2 !== 4'd0 || swd2 !== 32'd0 || rv2 !== 2'b00) begin
      errors++;
      $display("FAIL reset: grant=%b we=%b addr=%h wdata=%h rsp=%b, required all zero", g2, swe2, sa2, swd2, rv2);
    end else $display("reset ok");
    tick();
    set2(2'b00, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0);
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    set2(2'b01, 2'b01, 4'd3, 4'd0, 32'hA5A5_0001, 32'd0);
    @(negedge clk);
    vectors++;
    if (g2 !== 2'b01 || swe2 !== 1'b1 || sa2 !== 4'd3 || swd2 !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL wr: grant=%b we=%b addr=%h wdata=%h, required 01 1 3 a5a50001", g2, swe2, sa2, swd2);
    end else $display("wr ok: grant=%b", g2);
    ref_mem[3] = 32'hA5A5_0001;
    tick();
    set2(2'b01, 2'b00, 4'd3, 4'd0, 32'd0, 32'd0);
    @(negedge clk);
    vectors++;
    if (g2 !== 2'b01 || swe2 !== 1'b0 || sa2 !== 4'd3 || swd2 !== 32'd0) begin
      errors++;
      $display("FAIL rd: grant=%b we=%b addr=%h wdata=%h, required 01 0 3 0", g2, swe2, sa2, swd2);
    end else $display("rd ok: grant=%b", g2);
    tick();
    sb_q.push_back('{2'b01, 32'hA5A5_0001});
    set2(2'b00, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0);
    @(negedge clk);
    vectors++;
    if (g2 !== 2'b00 || swe2 !== 1'b0 || sa2 !== 4'd0) begin
      errors++;
      $display("FAIL idle: grant=%b we=%b addr=%h, required 00 0 0", g2, swe2, sa2);
    end else $display("idle ok");
    tick();
  endtask

  task automatic test_reset_mid_read();
    set2(2'b01, 2'b01, 4'd8, 4'd0, 32'h0000_0008, 32'd0);
    tick();
    ref_mem[8] = 32'h0000_0008;
    set2(2'b10, 2'b00, 4'd0, 4'd4, 32'd0, 32'd0);
    @(negedge clk);
    vectors++;
    if (g2 !== 2'b10) begin
      errors++;
      $display("FAIL midrd_grant: grant=%b, required 10", g2);
    end else $display("midrd grant ok");
    #2 rst = 1'b1;
    tick();
    set2(2'b00, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0);
    tick();
    rst = 1'b0;
    set2(2'b11, 2'b11, 4'd1, 4'd2, 32'h0000_0011, 32'h0000_0022);
    @(negedge clk);
    vectors++;
    if (g2 !== 2'b01 || sa2 !== 4'd1) begin
      errors++;
      $display("FAIL midrd_rrptr: grant=%b addr=%h, required 01 1", g2, sa2);
    end else $display("midrd rr_ptr ok");
    ref_mem[1] = 32'h0000_0011;
    tick();
    set2(2'b00, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0);
    tick();
  endtask

  task automatic test_contention();
    logic [1:0] exp_g;
    logic [31:0] wd;
    reset_pulse();
    for (int c = 0; c < 4; c++) begin
      wd = 32'h1000_0000 + 32'(c / 2);
`ifdef SRAM_ARB_WR_PRIO_EN
      wd = 32'h1000_0000 + 32'(c);
      exp_g = 2'b01;
`else
      exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
`endif
      set2(2'b11, 2'b01, 4'd5, 4'd5, wd, 32'd0);
      @(negedge clk);
      vectors++;
      if (g2 !== exp_g || sa2 !== 4'd5) begin
        errors++;
        $display("FAIL contention[%0d]: grant=%b addr=%h, required %b 5", c, g2, sa2, exp_g);
      end else $display("contention[%0d] ok: grant=%b", c, g2);
      if (exp_g == 2'b01) ref_mem[5] = wd;
      tick();
      if (exp_g == 2'b10) sb_q.push_back('{2'b10, ref_mem[5]});
    end
    set2(2'b00, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0);
    tick();
  endtask

  task automatic test_withdraw();
    reset_pulse();
    set2(2'b11, 2'b11, 4'd0, 4'd9, 32'h0000_00C0, 32'h0000_DEAD);
    @(negedge clk);
    vectors++;
    if (g2 !== 2'b01 || sa2 !== 4'd0) begin
      errors++;
      $display("FAIL withdraw_hold: grant=%b addr=%h, required 01 0", g2, sa2);
    end else $display("withdraw hold ok");
    ref_mem[0] = 32'h0000_00C0;
    tick();
    set2(2'b00, 2'b10, 4'd0, 4'd9, 32'd0, 32'h0000_DEAD);
    @(negedge clk);
    vectors++;
    if (g2 !== 2'b00 || swe2 !== 1'b0) begin
      errors++;
      $display("FAIL withdraw_drop: grant=%b we=%b, required 00 0", g2, swe2);
    end else $display("withdraw drop ok");
    tick();
    set2(2'b01, 2'b00, 4'd9, 4'd0, 32'd0, 32'd0);
    @(negedge clk);
    vectors++;
    if (g2 !== 2'b01 || sa2 !== 4'd9) begin
      errors++;
      $display("FAIL withdraw_rd: grant=%b addr=%h, required 01 9", g2, sa2);
    end else $display("withdraw readback grant ok");
    tick();
    sb_q.push_back('{2'b01, 32'd0});
    set2(2'b00, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0);
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g [3] = '{2'b01, 2'b10, 2'b01};
    logic [1:0] vv [3]    = '{2'b01, 2'b10, 2'b01};
    logic [1:0] ww [3]    = '{2'b00, 2'b10, 2'b00};
    for (int c = 0; c < 3; c++) begin
      set2(vv[c], ww[c], 4'd3, 4'd3, 32'd0, 32'hBEEF_0003);
      @(negedge clk);
      vectors++;
      if (g2 !== exp_g[c] || swe2 !== ww[c][1]) begin
        errors++;
        $display("FAIL b2b[%0d]: grant=%b we=%b, required %b %b", c, g2, swe2, exp_g[c], ww[c][1]);
      end else $display("b2b[%0d] ok: grant=%b", c, g2);
      if (ww[c][1]) ref_mem[3] = 32'hBEEF_0003;
      tick();
      if (!ww[c][1]) sb_q.push_back('{exp_g[c], ref_mem[3]});
    end
    set2(2'b00, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0);
    tick();
  endtask

  task automatic test_wrap3();
    logic [2:0] vv [4]    = '{3'b100, 3'b010, 3'b111, 3'b111};
    logic [2:0] exp_g [4] = '{3'b100, 3'b010, 3'b100, 3'b001};
    logic [3:0] exp_a [4] = '{4'hC, 4'hB, 4'hC, 4'hA};
    a3 = {4'hC, 4'hB, 4'hA};
    d3 = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    we3 = 3'b111;
    for (int c = 0; c < 4; c++) begin
      v3 = vv[c];
      @(negedge clk);
      vectors++;
      if (g3 !== exp_g[c] || sa3 !== exp_a[c] || swe3 !== 1'b1 || rv3 !== 3'b000) begin
        errors++;
        $display("FAIL wrap3[%0d]: grant=%b addr=%h we=%b rsp=%b, required %b %h 1 000",
                 c, g3, sa3, swe3, rv3, exp_g[c], exp_a[c]);
      end else $display("wrap3[%0d] ok: grant=%b", c, g3);
      tick();
    end
    v3 = '0;
    we3 = '0;
    tick();
  endtask

`ifdef SRAM_ARB_WR_PRIO_EN
  task automatic test_wr_prio();
    logic [1:0] exp_g;
    for (int c = 0; c < 4; c++) begin
      if (c < 3) set2(2'b11, 2'b10, 4'd7, 4'd7, 32'd0, 32'h7000_0000 + 32'(c));
      else       set2(2'b01, 2'b00, 4'd7, 4'd7, 32'd0, 32'd0);
      exp_g = (c < 3) ? 2'b10 : 2'b01;
      @(negedge clk);
      vectors++;
      if (g2 !== exp_g) begin
        errors++;
        $display("FAIL wr_prio[%0d]: grant=%b, required %b", c, g2, exp_g);
      end else $display("wr_prio[%0d] ok: grant=%b", c, g2);
      if (c < 3) ref_mem[7] = 32'h7000_0000 + 32'(c);
      tick();
      if (c == 3) sb_q.push_back('{2'b01, ref_mem[7]});
    end
    set2(2'b00, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0);
    tick();
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_write_read();
    test_reset_mid_read();
    test_contention();
    test_withdraw();
    test_back_to_back();
    test_wrap3();
`ifdef SRAM_ARB_WR_PRIO_EN
    test_wr_prio();
`endif
    tick();
    tick();
    vectors++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
